// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read/write/allocate bus for the scoreboarded register file
interface reg_file_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);
    logic [AW-1:0]   A1, A2, A3, AA;
    logic [XLEN-1:0] RD1, RD2, WD3;
    logic            RDY1, RDY2, WE3, ALLOC, ALLOC_OK;
    logic [NREGS-1:0] BUSY;
    logic [AW:0]     PENDING;
    modport master (
        output A1, A2, WE3, A3, WD3, ALLOC, AA,
        input  RD1, RD2, RDY1, RDY2, ALLOC_OK, BUSY, PENDING
    );
    modport slave (
        input  A1, A2, WE3, A3, WD3, ALLOC, AA,
        output RD1, RD2, RDY1, RDY2, ALLOC_OK, BUSY, PENDING
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R1W register file with x0 hardwired to zero and a pending-write scoreboard
module reg_file_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         reset,
    reg_file_sb_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      pending_q, pending_d;
    logic             wr, hit1, hit2, set, inc, dec;

    assign wr   = bus.WE3 && bus.A3 != '0;
    // forwarding is suppressed during reset so reads show the cleared array
    assign hit1 = BYPASS != 0 && !reset && bus.WE3 && bus.A3 == bus.A1;
    assign hit2 = BYPASS != 0 && !reset && bus.WE3 && bus.A3 == bus.A2;

    assign bus.RD1  = bus.A1 == '0 ? '0 : hit1 ? bus.WD3 : regs_q[bus.A1];
    assign bus.RD2  = bus.A2 == '0 ? '0 : hit2 ? bus.WD3 : regs_q[bus.A2];
    assign bus.RDY1 = !busy_q[bus.A1] || hit1;
    assign bus.RDY2 = !busy_q[bus.A2] || hit2;

    assign bus.ALLOC_OK = bus.AA == '0 || !busy_q[bus.AA] || (bus.WE3 && bus.A3 == bus.AA);
    assign bus.BUSY     = busy_q;
    assign bus.PENDING  = pending_q;

    assign set = bus.ALLOC && bus.ALLOC_OK && bus.AA != '0;
    assign inc = set && !busy_q[bus.AA];
    assign dec = wr && busy_q[bus.A3] && !(set && bus.AA == bus.A3);
    assign pending_d = pending_q + (AW+1)'(inc) - (AW+1)'(dec);

    // writeback clears first so a same-cycle allocation of that register wins
    always_comb begin
        busy_d = busy_q;
        if (wr) busy_d[bus.A3] = 1'b0;
        if (set) busy_d[bus.AA] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // register array; x0 is never written so it stays zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wr) begin
            regs_q[bus.A3] <= bus.WD3;
        end
    end

    // scoreboard vector and its population count advance together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; power of two, at least 4.
REQ-003 SHALL have parameter BYPASS, default 1, where 1 enables the write-to-read forwarding path.
REQ-004 SHALL derive AW = log2(NREGS) as the address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports A1 and A2, input, AW bits each: read addresses.
REQ-008 SHALL have ports RD1 and RD2, output, XLEN bits each: read data.
REQ-009 SHALL have ports RDY1 and RDY2, output, 1 bit each: the read operand carries no pending write.
REQ-010 SHALL have port WE3, input, 1 bit: write (writeback) enable.
REQ-011 SHALL have port A3, input, AW bits: write address.
REQ-012 SHALL have port WD3, input, XLEN bits: write data.
REQ-013 SHALL have port ALLOC, input, 1 bit: request to mark a destination register as pending.
REQ-014 SHALL have port AA, input, AW bits: allocation address.
REQ-015 SHALL have port ALLOC_OK, output, 1 bit: the allocation is accepted this cycle.
REQ-016 SHALL have port BUSY, output, NREGS bits: the scoreboard vector, bit i = register i pending.
REQ-017 SHALL have port PENDING, output, AW+1 bits: the count of set BUSY bits.

Function
REQ-018 SHALL drive RD1 and RD2 combinationally from the register array, with zero-cycle read latency.
REQ-019 SHALL return 0 on RDn when An = 0, SHALL ignore writes to A3 = 0, and SHALL hold BUSY[0] at 0 permanently.
REQ-020 SHALL write WD3 into register A3 on the rising clk edge when WE3 = 1 and A3 != 0, whether or not BUSY[A3] is set.
REQ-021 With BYPASS = 1, when WE3 = 1, A3 = An and An != 0, RDn SHALL equal WD3 in the same cycle.
REQ-022 With BYPASS = 0, RDn SHALL show the old value until the edge after the write.
REQ-023 SHALL compute RDYn = !BUSY[An]; with BYPASS = 1, RDYn SHALL also be 1 when WE3 = 1 and A3 = An.
REQ-024 SHALL compute ALLOC_OK = (AA = 0) OR !BUSY[AA] OR (WE3 = 1 AND A3 = AA), combinationally and independent of ALLOC.
REQ-025 SHALL set BUSY[AA] on the edge when ALLOC = 1, ALLOC_OK = 1 and AA != 0.
REQ-026 When ALLOC = 1 and ALLOC_OK = 0, SHALL leave all state unchanged; the requester stalls and retries.
REQ-027 SHALL clear BUSY[A3] on the edge when WE3 = 1 and A3 != 0, unless an accepted allocation targets the same address.
REQ-028 On simultaneous writeback and accepted allocation to the same register, SHALL write the data and leave BUSY set: the new allocation wins.
REQ-029 SHALL update set and clear operations to different registers in the same cycle independently.
REQ-030 SHALL update PENDING registered, in step with BUSY: +1, -1 or unchanged per edge; it SHALL never exceed NREGS-1 or wrap.

Reset
REQ-031 While reset is high, SHALL asynchronously clear all registers to 0, BUSY to 0 and PENDING to 0.
REQ-032 During and immediately after reset, RD1 = RD2 = 0, RDY1 = RDY2 = 1 and ALLOC_OK = 1.
REQ-033 Reset asserted mid-operation SHALL discard every pending allocation and any write in that cycle.
REQ-034 The first write after reset deassertion SHALL take effect on the first rising edge with reset low.

Verification
REQ-035 Reset, then write 0xDEADBEEF to x5 and 0x1234 to x0; read A1 = 5, A2 = 0 -> RD1 = 0xDEADBEEF, RD2 = 0.
REQ-036 BYPASS = 1: WE3 = 1, A3 = 7, WD3 = 0xA5A5, A1 = 7 in the same cycle -> RD1 = 0xA5A5 and RDY1 = 1 before the edge; BYPASS = 0 -> RD1 = old value.
REQ-037 Allocate x9 -> BUSY[9] = 1, PENDING = 1, RDY1 = 0 for A1 = 9; re-allocate x9 -> ALLOC_OK = 0, no change; writeback x9 -> BUSY[9] = 0, PENDING = 0.
REQ-038 Writeback x4 and allocate x4 in the same cycle -> x4 updated, BUSY[4] = 1, PENDING unchanged.
REQ-039 Allocate x1..x31 on consecutive cycles -> PENDING = 31; assert reset mid-sequence -> BUSY = 0, PENDING = 0, all reads 0 immediately.
REQ-040 Allocate x0 -> ALLOC_OK = 1, BUSY unchanged, PENDING unchanged.
